fixed_acc_win: RTL and testbench
================================

Name: fixed_acc_win

Overview:
- Parametrised successor of the 128-entry fixed-point control shell.
- Accumulates a window of LEN signed fixed-point samples.
- Emits one rounded, scaled and saturated result per window over a valid/ready handshake.
- Sits in the datapath after a sample source and before a downstream consumer.
- Keeps the family control trio: reset, init (soft reset) and in_disable (freeze).

Parameters:
- WIDTH, 32: sample and result width in bits, two's complement. Minimum 2.
- LEN, 128: samples per window. Minimum 1.
- SHIFT, 7: right shift applied to the window sum. Default gives the mean of 128 samples. Range 0..AW-1.
- ROUND, 1: 1 = round half toward +inf before the shift; 0 = truncate.
- Derived (localparam): CW = clog2(LEN+1); AW = WIDTH + clog2(LEN).

Ports:
- fixed_acc_win_clk  in  1  clock; all logic on the rising edge.
- fixed_acc_win_reset  in  1  synchronous active-high reset.
- fixed_acc_win_init  in  1  synchronous active-high soft reset; same effect as reset.
- fixed_acc_win_in_disable  in  1  freeze; all state holds while high.
- fixed_acc_win_in_data  in  WIDTH  signed input sample.
- fixed_acc_win_in_valid  in  1  in_data is valid.
- fixed_acc_win_in_ready  out  1  block can accept a sample.
- fixed_acc_win_out_data  out  WIDTH  signed result, registered.
- fixed_acc_win_out_valid  out  1  out_data is valid.
- fixed_acc_win_out_ready  in  1  consumer accepts the result.
- fixed_acc_win_out_sat  out  1  result was clipped; qualified by out_valid.
- fixed_acc_win_count  out  CW  samples accepted in the current window.

Behaviour:
- reset_i = reset | init. Both are synchronous, active high, and take priority over in_disable.
- Reset values:
  - state = ACC; accumulator = 0; count = 0.
  - out_data = 0; out_valid = 0; out_sat = 0.
  - in_ready = 1 from the first cycle after reset deasserts.
- in_ready and out_valid are combinational from state and in_disable:
  - in_ready = (state==ACC) & !in_disable.
  - out_valid = (state==OUT) & !in_disable.
- in_disable high:
  - in_ready = 0 and out_valid = 0.
  - Accumulator, count, state, out_data and out_sat all hold.
- Accept event = in_valid & in_ready.
- Pop event = out_valid & out_ready.
- State ACC:
  - On accept: acc <= acc + sign-extended in_data (AW bits, cannot overflow); count <= count + 1.
  - If the accept brings count to LEN: go to OUT on the next edge and register out_data/out_sat from the final sum.
  - Latency: last sample accepted at edge t; out_valid high after edge t.
- Result formation:
  - s = acc_final + (ROUND && SHIFT>0 ? 2^(SHIFT-1) : 0).
  - q = s >>> SHIFT (arithmetic shift).
  - If q > 2^(WIDTH-1)-1: out_data = max value, out_sat = 1.
  - If q < -2^(WIDTH-1): out_data = min value, out_sat = 1.
  - Otherwise out_data = q, out_sat = 0.
- State OUT:
  - in_ready = 0; count holds at LEN; out_data holds.
  - On pop: next edge clears acc and count and returns to ACC.
  - out_valid drops and in_ready rises in the same cycle; there is no overlap of the two.
  - out_sat clears on pop. out_data retains its last value.
- Boundaries:
  - LEN=1: every accepted sample produces a result; throughput is one sample per 2 cycles.
  - reset_i mid-window or during OUT discards the partial sum and any pending result.
  - in_valid while in OUT is ignored; no sample is lost because in_ready = 0.
  - out_ready with out_valid = 0 has no effect.

Test Plan:
- Reset then 128 samples of 0x0001_0000 (1.0 in Q16), default params, out_ready = 1 → out_data = 0x0001_0000, out_sat = 0, out_valid exactly 1 cycle after the 128th accept.
- Samples alternating +3 and -2 (raw), SHIFT = 0, LEN = 4 → out_data = 2. With SHIFT = 1, ROUND = 1 → 1; with ROUND = 0 → 1. Sum 3: ROUND=1 → 2, ROUND=0 → 1.
- WIDTH = 8, LEN = 4, SHIFT = 0, four samples of 0x7F → out_data = 0x7F, out_sat = 1. Four samples of 0x80 → 0x80, out_sat = 1.
- Hold out_ready = 0 for 10 cycles with in_valid = 1 → out_valid stays 1, in_ready stays 0, count = LEN, no accumulation. Raise out_ready → next cycle in_ready = 1 and count = 0.
- Pulse in_disable for 5 cycles mid-window at count = 50 → count stays 50, in_ready = 0, final result equals the undisturbed reference sum.
- Assert init at count = 77, then feed a full window → count restarts at 0 and the result excludes the first 77 samples. Repeat the init pulse during OUT → pending result dropped, out_valid = 0.

Source files
------------

// File: rtl/fixed_acc_win.sv
// Windowed accumulator: sums LEN signed samples, then emits one rounded,
// scaled and saturated result per window over a valid/ready handshake.
module fixed_acc_win #(
  parameter int WIDTH = 32,
  parameter int LEN   = 128,
  parameter int SHIFT = 7,
  parameter int ROUND = 1,
  localparam int CW   = $clog2(LEN + 1),
  localparam int AW   = WIDTH + $clog2(LEN)
) (
  input  logic                    fixed_acc_win_clk,
  input  logic                    fixed_acc_win_reset,
  input  logic                    fixed_acc_win_init,
  input  logic                    fixed_acc_win_in_disable,
  input  logic signed [WIDTH-1:0] fixed_acc_win_in_data,
  input  logic                    fixed_acc_win_in_valid,
  output logic                    fixed_acc_win_in_ready,
  output logic signed [WIDTH-1:0] fixed_acc_win_out_data,
  output logic                    fixed_acc_win_out_valid,
  input  logic                    fixed_acc_win_out_ready,
  output logic                    fixed_acc_win_out_sat,
  output logic [CW-1:0]           fixed_acc_win_count
);

  typedef enum logic {ST_ACC, ST_OUT} state_t;

  localparam logic [CW-1:0] LAST = CW'(LEN - 1);
  localparam int            RSH  = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [AW:0] RND_ADD =
    (ROUND != 0 && SHIFT > 0) ? ((AW + 1)'(1) << RSH) : '0;
  localparam logic signed [WIDTH-1:0] MAX_D = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MIN_D = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [AW:0]      MAX_Q = (AW + 1)'(MAX_D);
  localparam logic signed [AW:0]      MIN_Q = (AW + 1)'(MIN_D);

  state_t                  r_state;
  state_t                  w_state_next;
  logic signed [AW-1:0]    r_acc;
  logic [CW-1:0]           r_count;
  logic signed [WIDTH-1:0] r_out_data;
  logic                    r_out_sat;

  logic                    w_reset;
  logic                    w_accept;
  logic                    w_pop;
  logic                    w_last;
  logic signed [AW-1:0]    w_acc_next;
  logic signed [AW:0]      w_sum_rnd;
  logic signed [AW:0]      w_q;
  logic signed [WIDTH-1:0] w_res_data;
  logic                    w_res_sat;

  assign w_reset  = fixed_acc_win_reset | fixed_acc_win_init;
  assign w_accept = fixed_acc_win_in_valid & fixed_acc_win_in_ready;
  assign w_pop    = fixed_acc_win_out_valid & fixed_acc_win_out_ready;
  assign w_last   = (r_count == LAST);

  assign fixed_acc_win_in_ready  = (r_state == ST_ACC) & ~fixed_acc_win_in_disable;
  assign fixed_acc_win_out_valid = (r_state == ST_OUT) & ~fixed_acc_win_in_disable;
  assign fixed_acc_win_out_data  = r_out_data;
  assign fixed_acc_win_out_sat   = r_out_sat;
  assign fixed_acc_win_count     = r_count;

  // AW bits hold LEN full-scale samples, so this add never overflows; the
  // extra bit on the rounded sum absorbs the rounding constant.
  assign w_acc_next = r_acc + AW'(fixed_acc_win_in_data);
  assign w_sum_rnd  = (AW + 1)'(w_acc_next) + RND_ADD;
  assign w_q        = w_sum_rnd >>> SHIFT;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the block leaves it unassigned and infers a latch.
    w_res_data = WIDTH'(w_q);
    w_res_sat  = 1'b0;
    if (w_q > MAX_Q) begin
      w_res_data = MAX_D;
      w_res_sat  = 1'b1;
    end else if (w_q < MIN_Q) begin
      w_res_data = MIN_D;
      w_res_sat  = 1'b1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_ACC: if (w_accept && w_last) w_state_next = ST_OUT;
      ST_OUT: if (w_pop)              w_state_next = ST_ACC;
      default:                        w_state_next = ST_ACC;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge fixed_acc_win_clk) begin
    if (w_reset) begin
      r_state <= ST_ACC;
    end else if (!fixed_acc_win_in_disable) begin
      r_state <= w_state_next;
    end
  end

  // accept and pop are already gated by in_disable, so freezing is implicit.
  always_ff @(posedge fixed_acc_win_clk) begin
    if (w_reset) begin
      r_acc      <= '0;
      r_count    <= '0;
      r_out_data <= '0;
      r_out_sat  <= 1'b0;
    end else if (w_accept) begin
      r_acc   <= w_acc_next;
      r_count <= r_count + CW'(1);
      if (w_last) begin
        r_out_data <= w_res_data;
        r_out_sat  <= w_res_sat;
      end
    end else if (w_pop) begin
      r_acc     <= '0;
      r_count   <= '0;
      r_out_sat <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fixed_acc_win.sv
// Directed bench for fixed_acc_win: default-parameter instance for long
// windows and control corner cases, three 8-bit LEN=4 instances for rounding.
module tb_fixed_acc_win;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, init, in_disable, out_ready;

  // default instance: WIDTH=32, LEN=128, SHIFT=7, ROUND=1
  logic [31:0] d_data, d_out_data;
  logic        d_valid, d_in_ready, d_out_valid, d_out_sat;
  logic [7:0]  d_count;

  // small instances: WIDTH=8, LEN=4; a: SHIFT=0, b: SHIFT=1 ROUND=1, c: SHIFT=1 ROUND=0
  logic [7:0] s_data;
  logic       s_valid;
  logic [7:0] a_data, b_data, c_data;
  logic       a_rdy, b_rdy, c_rdy, a_ov, b_ov, c_ov, a_sat, b_sat, c_sat;
  logic [2:0] a_cnt, b_cnt, c_cnt;

  fixed_acc_win u_def (
    .fixed_acc_win_clk(clk), .fixed_acc_win_reset(reset), .fixed_acc_win_init(init),
    .fixed_acc_win_in_disable(in_disable), .fixed_acc_win_in_data(d_data),
    .fixed_acc_win_in_valid(d_valid), .fixed_acc_win_in_ready(d_in_ready),
    .fixed_acc_win_out_data(d_out_data), .fixed_acc_win_out_valid(d_out_valid),
    .fixed_acc_win_out_ready(out_ready), .fixed_acc_win_out_sat(d_out_sat),
    .fixed_acc_win_count(d_count));

  fixed_acc_win #(.WIDTH(8), .LEN(4), .SHIFT(0), .ROUND(1)) u_a (
    .fixed_acc_win_clk(clk), .fixed_acc_win_reset(reset), .fixed_acc_win_init(init),
    .fixed_acc_win_in_disable(in_disable), .fixed_acc_win_in_data(s_data),
    .fixed_acc_win_in_valid(s_valid), .fixed_acc_win_in_ready(a_rdy),
    .fixed_acc_win_out_data(a_data), .fixed_acc_win_out_valid(a_ov),
    .fixed_acc_win_out_ready(out_ready), .fixed_acc_win_out_sat(a_sat),
    .fixed_acc_win_count(a_cnt));

  fixed_acc_win #(.WIDTH(8), .LEN(4), .SHIFT(1), .ROUND(1)) u_b (
    .fixed_acc_win_clk(clk), .fixed_acc_win_reset(reset), .fixed_acc_win_init(init),
    .fixed_acc_win_in_disable(in_disable), .fixed_acc_win_in_data(s_data),
    .fixed_acc_win_in_valid(s_valid), .fixed_acc_win_in_ready(b_rdy),
    .fixed_acc_win_out_data(b_data), .fixed_acc_win_out_valid(b_ov),
    .fixed_acc_win_out_ready(out_ready), .fixed_acc_win_out_sat(b_sat),
    .fixed_acc_win_count(b_cnt));

  fixed_acc_win #(.WIDTH(8), .LEN(4), .SHIFT(1), .ROUND(0)) u_c (
    .fixed_acc_win_clk(clk), .fixed_acc_win_reset(reset), .fixed_acc_win_init(init),
    .fixed_acc_win_in_disable(in_disable), .fixed_acc_win_in_data(s_data),
    .fixed_acc_win_in_valid(s_valid), .fixed_acc_win_in_ready(c_rdy),
    .fixed_acc_win_out_data(c_data), .fixed_acc_win_out_valid(c_ov),
    .fixed_acc_win_out_ready(out_ready), .fixed_acc_win_out_sat(c_sat),
    .fixed_acc_win_count(c_cnt));

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int samp(input int k, input int seed);
    if (seed < 0) return 32'h0001_0000;
    return ((k * 7919 + seed * 104729) % 200000) - 100000;
  endfunction

  // Reference for the default instance: +64 rounding, >>>7, clip to 32 bits.
  function automatic void model(input longint sum, output logic [31:0] q, output bit sat);
    longint t;
    t = (sum + 64) >>> 7;
    sat = 1'b0;
    if (t > 64'sd2147483647) begin
      q = 32'h7FFF_FFFF; sat = 1'b1;
    end else if (t < -64'sd2147483648) begin
      q = 32'h8000_0000; sat = 1'b1;
    end else begin
      q = t[31:0];
    end
  endfunction

  // Feeds n samples; returns at the negedge after the last accepting edge.
  task automatic feed_def(input int n, input int start, input int seed, inout longint sum);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      d_data  = samp(start + k, seed);
      d_valid = 1'b1;
      check("def_in_ready", d_in_ready, 1);
      check("def_no_early_valid", d_out_valid, 0);
      check("def_count", d_count, start + k);
      sum += samp(start + k, seed);
    end
    @(negedge clk);
    d_valid = 1'b0;
  endtask

  task automatic check_def_result(input longint sum);
    logic [31:0] q;
    bit          sat;
    model(sum, q, sat);
    check("def_out_valid", d_out_valid, 1);
    check("def_out_data", d_out_data, q);
    check("def_out_sat", d_out_sat, sat);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("def_pop_valid_low", d_out_valid, 0);
    check("def_pop_in_ready", d_in_ready, 1);
    check("def_pop_count", d_count, 0);
    check("def_pop_sat_clear", d_out_sat, 0);
  endtask

  typedef struct {
    logic [3:0][7:0] s;
    logic [7:0] qa; bit sa;
    logic [7:0] qb; bit sb;
    logic [7:0] qc; bit sc;
  } vec_t;

  vec_t vecs[8];

  initial begin
    longint sum;

    vecs[0] = '{{8'h03, 8'hFE, 8'h03, 8'hFE}, 8'h02, 0, 8'h01, 0, 8'h01, 0};
    vecs[1] = '{{8'h01, 8'h01, 8'h01, 8'h00}, 8'h03, 0, 8'h02, 0, 8'h01, 0};
    vecs[2] = '{{8'h7F, 8'h7F, 8'h7F, 8'h7F}, 8'h7F, 1, 8'h7F, 1, 8'h7F, 1};
    vecs[3] = '{{8'h80, 8'h80, 8'h80, 8'h80}, 8'h80, 1, 8'h80, 1, 8'h80, 1};
    vecs[4] = '{{8'hFD, 8'h00, 8'h00, 8'h00}, 8'hFD, 0, 8'hFF, 0, 8'hFE, 0};
    vecs[5] = '{{8'h64, 8'h64, 8'hCE, 8'h05}, 8'h7F, 1, 8'h4E, 0, 8'h4D, 0};
    vecs[6] = '{{8'hC0, 8'hC0, 8'h00, 8'h00}, 8'h80, 0, 8'hC0, 0, 8'hC0, 0};
    vecs[7] = '{{8'h7F, 8'h00, 8'h00, 8'h00}, 8'h7F, 0, 8'h40, 0, 8'h3F, 0};

    reset = 1'b1; init = 1'b0; in_disable = 1'b0; out_ready = 1'b0;
    d_data = '0; d_valid = 1'b0; s_data = '0; s_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", d_in_ready, 1);
    check("rst_out_valid", d_out_valid, 0);
    check("rst_count", d_count, 0);
    check("rst_out_data", d_out_data, 0);
    check("rst_out_sat", d_out_sat, 0);

    // 128 x 1.0 in Q16 with out_ready held high: mean is 1.0
    out_ready = 1'b1;
    sum = 0;
    feed_def(128, 0, -1, sum);
    check("q16_mean_value", d_out_data, 32'h0001_0000);
    check_def_result(sum);

    // result held while out_ready low; in_valid ignored in OUT
    sum = 0;
    feed_def(128, 0, 1, sum);
    d_valid = 1'b1;
    d_data  = 32'h1234_5678;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_out_valid", d_out_valid, 1);
      check("hold_in_ready", d_in_ready, 0);
      check("hold_count", d_count, 128);
    end
    d_valid = 1'b0;
    check_def_result(sum);

    // freeze for 5 cycles at count 50
    sum = 0;
    feed_def(50, 0, 2, sum);
    in_disable = 1'b1;
    d_valid    = 1'b1;
    d_data     = 32'h7FFF_0000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("dis_count", d_count, 50);
      check("dis_in_ready", d_in_ready, 0);
    end
    in_disable = 1'b0;
    d_valid    = 1'b0;
    feed_def(78, 50, 2, sum);
    check_def_result(sum);

    // soft reset mid-window discards the partial sum
    sum = 0;
    feed_def(77, 0, 5, sum);
    init    = 1'b1;
    d_valid = 1'b1;
    @(negedge clk);
    init    = 1'b0;
    d_valid = 1'b0;
    check("init_count", d_count, 0);
    check("init_in_ready", d_in_ready, 1);
    sum = 0;
    feed_def(128, 0, 3, sum);
    check_def_result(sum);

    // soft reset during OUT drops the pending result
    sum = 0;
    feed_def(128, 0, 4, sum);
    check("pre_init_valid", d_out_valid, 1);
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    check("init_out_valid", d_out_valid, 0);
    check("init_out_count", d_count, 0);
    check("init_out_data", d_out_data, 0);
    check("init_out_sat", d_out_sat, 0);
    check("init_out_in_ready", d_in_ready, 1);

    // 8-bit rounding / saturation table
    for (int v = 0; v < 8; v++) begin
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        s_data  = vecs[v].s[k];
        s_valid = 1'b1;
        check("small_in_ready", a_rdy & b_rdy & c_rdy, 1);
      end
      @(negedge clk);
      s_valid = 1'b0;
      check("a_valid", a_ov, 1);
      check("a_data", a_data, vecs[v].qa);
      check("a_sat", a_sat, vecs[v].sa);
      check("b_data", b_data, vecs[v].qb);
      check("b_sat", b_sat, vecs[v].sb);
      check("c_data", c_data, vecs[v].qc);
      check("c_sat", c_sat, vecs[v].sc);
      check("small_count", a_cnt, 4);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("small_pop", {a_ov, b_ov, c_ov, a_rdy, b_rdy, c_rdy}, 6'b000111);
      check("small_pop_count", b_cnt, 0);
      check("small_pop_data_kept", c_data, vecs[v].qc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
